// File: rtl/video_timing_rx.sv
// video_timing_rx: recovers raster timing from an HS/VS/DE stream, qualifies lock over
// two identical frames and reports raster type plus live active-area coordinates.
module video_timing_rx (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic       hs,
  input  logic       vs,
  input  logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [9:0] total_h,
  output logic [9:0] total_v,
  output logic [9:0] active_w,
  output logic [9:0] active_h,
  output logic       locked,
  output logic       pal,
  output logic       ntsc,
  output logic       line_start,
  output logic       frame_start
);
  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;
  state_t st_q, st_d;
  logic hv_q, hs_q, vs_ls_q, err_q, err_d, ls_q, fs_q, locked_q, pal_q, ntsc_q;
  logic [9:0] h_q, h_d, w_q, w_d, v_q, v_d, a_q, a_d, wf_q, wf_d, len_q, len_d, x_q, x_d, y_q, y_d;
  logic [39:0] cand_q, cand_d, pub_q, pub_d, meas;
  logic ls, fs, tmo, err_now;
  logic [9:0] line_len, len_ref, wf_now, a_now;
  // Sync history is only trusted after one real sample, so levels already high at reset release are ignored.
  assign ls = ce_pix & hv_q & hs & ~hs_q;
  assign fs = ls & vs & ~vs_ls_q;
  assign line_len = h_q + 10'd1;
  assign len_ref = (v_q == 10'd0) ? line_len : len_q;
  assign wf_now = (|w_q) ? w_q : wf_q;
  assign a_now = a_q + {9'd0, |w_q};
  assign err_now = err_q | (line_len != len_ref) | ((|w_q) & (|wf_q) & (w_q != wf_q));
  assign meas = {line_len, v_q + 10'd1, wf_now, a_now};
  assign tmo = ce_pix & ((&h_d) | (&v_d));
  always_comb begin
    h_d = h_q; w_d = w_q; x_d = x_q; v_d = v_q; y_d = y_q;
    a_d = a_q; wf_d = wf_q; len_d = len_q; err_d = err_q;
    if (ce_pix) begin
      h_d = ls ? 10'd0 : (&h_q) ? h_q : h_q + 10'd1;
      w_d = ls ? {9'd0, de} : (&w_q) ? w_q : w_q + {9'd0, de};
      x_d = ls ? 10'd0 : de ? w_q : x_q;
    end
    if (ls) begin
      v_d = fs ? 10'd0 : (&v_q) ? v_q : v_q + 10'd1;
      y_d = fs ? 10'd0 : y_q + {9'd0, |w_q};
      a_d = fs ? 10'd0 : a_now;
      wf_d = fs ? 10'd0 : wf_now;
      err_d = fs ? 1'b0 : err_now;
      len_d = len_ref;
    end
  end
  always_comb begin
    st_d = st_q; cand_d = cand_q; pub_d = pub_q;
    if (tmo) st_d = SEARCH;
    else if (fs) begin
      case (st_q)
        SEARCH: begin cand_d = meas; st_d = CHECK; end
        CHECK: begin
          if (meas == cand_q && !err_now) begin st_d = LOCKED; pub_d = meas; end
          else cand_d = meas;
        end
        default: st_d = (meas != cand_q || err_now) ? SEARCH : LOCKED;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q <= SEARCH; hv_q <= 1'b0; hs_q <= 1'b0; vs_ls_q <= 1'b0; err_q <= 1'b0;
      ls_q <= 1'b0; fs_q <= 1'b0; locked_q <= 1'b0; pal_q <= 1'b0; ntsc_q <= 1'b0;
      h_q <= '0; w_q <= '0; v_q <= '0; a_q <= '0; wf_q <= '0; len_q <= '0; x_q <= '0; y_q <= '0;
      cand_q <= '0; pub_q <= '0;
    end else begin
      if (ce_pix) begin
        hv_q <= 1'b1;
        hs_q <= hs;
        if (ls || !hv_q) vs_ls_q <= vs;
      end
      st_q <= st_d; cand_q <= cand_d; pub_q <= pub_d; err_q <= err_d;
      h_q <= h_d; w_q <= w_d; v_q <= v_d; a_q <= a_d; wf_q <= wf_d; len_q <= len_d; x_q <= x_d; y_q <= y_d;
      ls_q <= ls; fs_q <= fs;
      locked_q <= st_d == LOCKED;
      pal_q <= (st_d == LOCKED) && (pub_d[29:20] == 10'd312);
      ntsc_q <= (st_d == LOCKED) && (pub_d[29:20] == 10'd262);
    end
  end
  assign {total_h, total_v, active_w, active_h} = pub_q;
  assign x = x_q;
  assign y = y_q;
  assign locked = locked_q;
  assign pal = pal_q;
  assign ntsc = ntsc_q;
  assign line_start = ls_q;
  assign frame_start = fs_q;
endmodule

// File: doc/video_timing_rx.md
# video_timing_rx

Recovers raster timing from the pixel-rate sync stream the core drives toward the video mixer/scaler (HS, VS, DE qualified by the pixel enable). It measures line length, frame height and active window size, gates on two consecutive identical frames before declaring lock, and reports 50/60 Hz raster type plus live active-area pixel coordinates. Consumers are the OSD/scaler side and the self-check logic that validates the frame generator against NES 341x262 (NTSC) / 341x312 (PAL) timing.

## Interface
- No parameters; all widths are fixed at 10 bits (raster limit 1023).
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ce_pix  in  1  pixel enable; every input is sampled and all state advances only on clk edges with ce_pix=1
- hs  in  1  horizontal sync, active-high
- vs  in  1  vertical sync, active-high
- de  in  1  data enable (active picture)
- x  out  10  active-area column of the current de pixel
- y  out  10  active-area row of the current de pixel
- total_h  out  10  pixels per line, last locked measurement
- total_v  out  10  lines per frame, last locked measurement
- active_w  out  10  de pixels per line, last locked measurement
- active_h  out  10  lines containing de, last locked measurement
- locked  out  1  timing stable
- pal  out  1  locked and total_v = 312
- ntsc  out  1  locked and total_v = 262
- line_start  out  1  one-clk pulse per detected line start
- frame_start  out  1  one-clk pulse per detected frame start

## Operation
- Line start (LS): ce_pix sample with hs=1 while previous ce_pix sample had hs=0.
- Frame start (FS): an LS where vs=1 and the vs value sampled at the previous LS was 0.
- h_cnt: cleared to 0 at LS, otherwise +1 per ce_pix, saturating at 1023. At LS, line_len = h_cnt+1 (sample count since the previous LS).
- w_cnt: counts de samples in the current line; cleared at LS. At LS, w_line = w_cnt; all w_line values > 0 within one frame must be equal, otherwise frame_err is set.
- v_cnt: cleared at FS, +1 at each other LS, saturating at 1023. Every line_len in a frame must equal the first; otherwise frame_err is set.
- a_cnt: number of lines in the frame with w_line > 0.
- At FS, the frame measurement is {line_len, v_cnt+1, w_line, a_cnt}, and frame_err is cleared for the new frame.
- x: cleared at LS; after each de sample it equals the count of de samples before it in the line. y: cleared at FS; incremented at LS following a line with w_line > 0.
- Lock FSM, states SEARCH, CHECK, LOCKED:
  - SEARCH: the first FS captures the measurement as the candidate and moves to CHECK.
  - CHECK: at the next FS, if the measurement equals the candidate and frame_err=0, go to LOCKED and publish it to total_h/total_v/active_w/active_h. Otherwise recapture the candidate and remain in CHECK.
  - LOCKED: at each FS, a mismatch or frame_err sends the FSM to SEARCH.
- Timeout: h_cnt reaching 1023, or v_cnt reaching 1023, forces SEARCH from any state.
- On entry to SEARCH, locked, pal and ntsc drop. The published measurements hold their last values until the next lock.
- Simultaneous events:
  - An FS that coincides with a timeout: the timeout wins.
  - hs and vs both rising on the same sample counts as an FS.
  - de=1 on an LS sample is counted in the new line.

## Timing
- Reset values:
  - All outputs are 0.
  - The FSM is in SEARCH.
  - The sync history registers are 0, so hs or vs already high when reset is released does not produce an LS or FS.
- line_start and frame_start are asserted on the clk edge that samples the qualifying ce_pix and last exactly one clk, regardless of ce_pix spacing.
- x and y update on the same edge that samples de; they hold between ce_pix pulses.
- Lock latency: locked rises on the edge that samples the 3rd FS after stable input. It falls on the edge that samples the offending FS or timeout.
- pal and ntsc are registered together with locked and are never both 1.
- Reset asserted mid-frame returns the block to reset values immediately. Measurement restarts from the next FS.

## Test plan
- NTSC raster: 341x262 timing, de on h 0–255 of lines 0–239, ce_pix 1-in-4, FS on line 244. Required: locked=1 at the 3rd FS; total_h=341, total_v=262, active_w=256, active_h=240; ntsc=1, pal=0.
- PAL raster: 341x312, FS on line 270. Required: locked and pal=1; total_v=312.
- Active-area coordinates (locked): at the final de pixel of a line x=255, and at the final de line y=239. After the next FS, x=0 and y=0 on the first de sample.
- Glitch frame: after lock, one line is shortened to 340. Required: locked drops at that frame's closing FS; after two clean frames, relock occurs at the 3rd FS with identical values.
- Sync loss: hs held low after lock. Required: locked=0 on the edge where h_cnt hits 1023; total_h stays at 341; no line_start pulses are produced.
- Reset mid-frame while hs=1: all outputs become 0 asynchronously. No LS is generated on release until hs falls and then rises again.
